// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock divider.
// Divisor values below DIV_MIN are clamped so a period always has a high and a low phase.
package clk_div_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int DIV_MIN = 2;

  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
  endfunction

endpackage

// File: rtl/clk_div_duty_fix.sv
// Stretches the posedge-generated clock by half a source cycle for odd divisors (50 % duty).
// Combinational OR of the posedge register and a negedge copy; the negedge term is gated off for even divisors.
module clk_div_duty_fix (
  input  logic clk,
  input  logic rst,
  input  logic i_clk_pos,
  input  logic i_odd,
  output logic o_clk_out
);

  logic r_clk_neg;

  always_ff @(negedge clk or posedge rst) begin
    if (rst) begin
      r_clk_neg <= 1'b0;
    end else begin
      r_clk_neg <= i_clk_pos;
    end
  end

  // r_clk_neg is low whenever a period boundary changes i_odd, so the gate cannot glitch.
  assign o_clk_out = i_clk_pos | (r_clk_neg & i_odd);

endmodule

// File: rtl/clk_div_prog.sv
// Programmable divider: clk_out period = clamp(div) clk cycles; start, stop and divisor swaps only on period boundaries.
// Outputs rise one edge after en is sampled high; CLK_DIV_DUTY50_EN adds half-cycle stretch for odd divisors.
module clk_div_prog
  import clk_div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] div,
  output logic             clk_out,
  output logic             tick,
  output logic             busy
);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_nxt;
  logic [WIDTH-1:0] r_div_act;
  logic [WIDTH-1:0] w_div_act_nxt;
  logic             r_clk_out;
  logic             w_clk_out_nxt;
  logic             r_tick;
  logic             w_tick_nxt;

  logic [WIDTH-1:0] w_div_clamp;
  logic [WIDTH-1:0] w_half;
  logic [WIDTH-1:0] w_cnt_inc;
  logic             w_last;

  assign w_div_clamp = WIDTH'(clamp_div(32'(div)));
  assign w_half      = r_div_act >> 1;
  assign w_cnt_inc   = r_cnt + WIDTH'(1);
  assign w_last      = (r_cnt == (r_div_act - WIDTH'(1)));

  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_nxt     = r_cnt;
    w_div_act_nxt = r_div_act;
    w_clk_out_nxt = 1'b0;
    w_tick_nxt    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nxt = '0;
        if (en) begin
          w_state_nxt   = RUN;
          w_div_act_nxt = w_div_clamp;
          w_clk_out_nxt = 1'b1;
          w_tick_nxt    = 1'b1;
        end
      end
      RUN: begin
        if (w_last) begin
          w_cnt_nxt = '0;
          if (en) begin
            w_div_act_nxt = w_div_clamp;
            w_clk_out_nxt = 1'b1;
            w_tick_nxt    = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end else begin
          w_cnt_nxt     = w_cnt_inc;
          w_clk_out_nxt = (w_cnt_inc < w_half);
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= '0;
      r_div_act <= WIDTH'(DIV_MIN);
      r_clk_out <= 1'b0;
      r_tick    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_div_act <= w_div_act_nxt;
      r_clk_out <= w_clk_out_nxt;
      r_tick    <= w_tick_nxt;
    end
  end

  assign tick = r_tick;
  assign busy = (r_state == RUN);

`ifdef CLK_DIV_DUTY50_EN
  clk_div_duty_fix u_duty_fix (
    .clk       (clk),
    .rst       (rst),
    .i_clk_pos (r_clk_out),
    .i_odd     (r_div_act[0]),
    .o_clk_out (clk_out)
  );
`else
  assign clk_out = r_clk_out;
`endif

endmodule

// File: tb/tb_clk_div_prog.sv
// Bench for clk_div_prog: directed table, hand-written corner sequences and a random run against a period-queue model.
// Honours CLK_DIV_DUTY50_EN so the same file checks either build.
module tb_clk_div_prog;

  localparam int WIDTH = 8;
`ifdef CLK_DIV_DUTY50_EN
  localparam bit DUTY = 1'b1;
`else
  localparam bit DUTY = 1'b0;
`endif

  logic             clk;
  logic             rst;
  logic             en;
  logic [WIDTH-1:0] div;
  logic             clk_out;
  logic             tick;
  logic             busy;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: one entry per clk cycle of a scheduled period; clk_out as seen after posedge and after negedge.
  typedef struct {
    bit pos;
    bit neg;
    bit tck;
  } ent_t;
  ent_t q[$];
  bit exp_pos, exp_neg, exp_tick, exp_busy;
  logic [2:0] last_pos;

  typedef struct {
    bit       r;
    bit       e;
    int       d;
    bit [2:0] exp;
  } vec_t;

  clk_div_prog #(.WIDTH(WIDTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .en      (en),
    .div     (div),
    .clk_out (clk_out),
    .tick    (tick),
    .busy    (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int clampn(int d);
    return (d < 2) ? 2 : d;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic push_period(int n);
    int   h;
    ent_t e;
    h = n / 2;
    for (int i = 0; i < n; i++) begin
      e.pos = (DUTY && (n % 2 == 1)) ? (i <= h) : (i < h);
      e.neg = (i < h);
      e.tck = (i == 0);
      q.push_back(e);
    end
  endtask

  task automatic model_edge();
    ent_t e;
    if (rst) begin
      q.delete();
      exp_pos = 0; exp_neg = 0; exp_tick = 0; exp_busy = 0;
      return;
    end
    if (q.size() == 0 && en) push_period(clampn(int'(div)));
    if (q.size() != 0) begin
      e = q.pop_front();
      exp_pos = e.pos; exp_neg = e.neg; exp_tick = e.tck; exp_busy = 1'b1;
    end else begin
      exp_pos = 0; exp_neg = 0; exp_tick = 0; exp_busy = 0;
    end
  endtask

  // One clk cycle: drive inputs, model the posedge, compare after posedge and after negedge.
  task automatic cyc(bit r, bit e, int d);
    rst = r;
    en  = e;
    div = WIDTH'(d);
    @(posedge clk);
    model_edge();
    #1;
    last_pos = {clk_out, tick, busy};
    check("model_pos", {29'd0, last_pos}, {29'd0, exp_pos, exp_tick, exp_busy});
    @(negedge clk);
    #1;
    check("model_neg_clk", {31'd0, clk_out}, {31'd0, exp_neg});
  endtask

  initial begin
    vec_t         tbl[$];
    logic [17:0]  got18;
    logic [5:0]   got6;
    int           busy_cnt;
    int           late_act;
    bit           r_en;
    int           r_div;

    rst = 1'b1;
    en  = 1'b0;
    div = '0;

    // Reset, div=3 run, then div=0 and div=1 behaving as div=2, then stop.
    tbl.push_back('{1, 0, 3, 3'b000});
    tbl.push_back('{0, 0, 3, 3'b000});
    tbl.push_back('{0, 1, 3, 3'b111});
    tbl.push_back('{0, 1, 3, {DUTY, 2'b01}});
    tbl.push_back('{0, 1, 3, 3'b001});
    tbl.push_back('{0, 1, 3, 3'b111});
    tbl.push_back('{0, 1, 3, {DUTY, 2'b01}});
    tbl.push_back('{0, 1, 0, 3'b001});
    tbl.push_back('{0, 1, 0, 3'b111});
    tbl.push_back('{0, 1, 1, 3'b001});
    tbl.push_back('{0, 1, 1, 3'b111});
    tbl.push_back('{0, 1, 2, 3'b001});
    tbl.push_back('{0, 0, 2, 3'b000});
    tbl.push_back('{0, 0, 2, 3'b000});
    foreach (tbl[i]) begin
      cyc(tbl[i].r, tbl[i].e, tbl[i].d);
      check($sformatf("table_row%0d", i), {29'd0, last_pos}, {29'd0, tbl[i].exp});
    end

    // div=8 running, div changed to 5 while cnt=2.
    got18 = '0;
    for (int i = 0; i < 18; i++) begin
      cyc(0, 1, (i < 3) ? 8 : 5);
      got18 = {got18[16:0], last_pos[2]};
    end
    check("div_change_pattern", {14'd0, got18},
          {14'd0, 8'b11110000, (DUTY ? 5'b11100 : 5'b11000), (DUTY ? 5'b11100 : 5'b11000)});
    repeat (6) cyc(0, 0, 5);

    // div=6, en dropped while cnt=1: full period, then silence.
    got6     = '0;
    busy_cnt = 0;
    cyc(0, 1, 6);
    got6 = {got6[4:0], last_pos[2]};
    busy_cnt += int'(last_pos[0]);
    for (int i = 1; i < 6; i++) begin
      cyc(0, 0, 6);
      got6 = {got6[4:0], last_pos[2]};
      busy_cnt += int'(last_pos[0]);
    end
    check("stop_period_pattern", {26'd0, got6}, {26'd0, 6'b111000});
    check("stop_busy_cycles", busy_cnt, 6);
    late_act = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 6);
      late_act += int'(last_pos[2]) + int'(last_pos[1]) + int'(last_pos[0]);
    end
    check("after_stop_quiet", late_act, 0);

    // Asynchronous reset at cnt=2 with div=7, then a fresh period.
    repeat (3) cyc(0, 1, 7);
    check("pre_rst_busy", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    #1;
    check("async_rst_outputs", {29'd0, clk_out, tick, busy}, 32'd0);
    q.delete();
    exp_pos = 0; exp_neg = 0; exp_tick = 0; exp_busy = 0;
    cyc(1, 1, 7);
    cyc(0, 1, 7);
    check("restart_first_cycle", {29'd0, last_pos}, {29'd0, 3'b111});
    cyc(0, 1, 7);
    check("restart_second_cycle", {29'd0, last_pos}, {29'd0, 3'b101});

    // Random run against the model.
    r_en  = 1'b1;
    r_div = 4;
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 19) == 0) r_en = ~r_en;
      if ($urandom_range(0, 7) == 0) begin
        r_div = ($urandom_range(0, 60) == 0) ? int'($urandom_range(100, 255))
                                              : int'($urandom_range(0, 12));
      end
      cyc(($urandom_range(0, 199) == 0), r_en, r_div);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
